fetch_prefetch_unit: RTL

Parametrised instruction-fetch front end with a prefetch queue.
- Generates sequential PCs and issues pipelined requests to an instruction memory with a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them downstream through a valid/ready handshake.
- On a control-flow redirect, flushes the queue and discards in-flight responses.
- Sits between the instruction memory interface and decode; replaces the single-instruction fetch stage.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_prefetch_unit_sync_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; storage resets to RESET_VAL so the head is defined out of reset.
module sync_fifo #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i & (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i & (cnt_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited pipelined
// requests, a PC tag queue paired with in-order responses, and a prefetch queue.
module fetch_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]     fifo_cnt, tag_cnt;
    logic [XLEN-1:0]   tag_head;
    logic [2*XLEN-1:0] fifo_head;
    logic [CW:0]       credit_sum;
    logic              credit_ok, req_fire, resp_fire, resp_keep, pop;

    assign credit_sum     = {1'b0, fifo_cnt} + {1'b0, out_cnt_q};
    assign credit_ok      = credit_sum < (CW+1)'(DEPTH);
    assign imem_req_valid = fetch_en & ~redirect & credit_ok & ~reset;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Stale responses never pop the tag queue: it was flushed at the redirect and
    // may already hold tags of post-redirect requests.
    assign resp_fire = imem_resp_valid & (out_cnt_q != '0);
    assign resp_keep = resp_fire & ~redirect & (drop_cnt_q == '0) & (tag_cnt != '0);

    assign instr_valid = (fifo_cnt != '0) & ~redirect;
    assign pop         = instr_valid & instr_ready;
    assign pc          = fifo_head[2*XLEN-1:XLEN];
    assign instr       = fifo_head[XLEN-1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(resp_fire);
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            drop_cnt_d = out_cnt_q - CW'(resp_fire);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (resp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH     (XLEN),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_PC)
    ) u_tag_q (
        .clk     (clk),
        .rst     (reset),
        .flush_i (redirect),
        .push_i  (req_fire),
        .wdata_i (fetch_pc_q),
        .pop_i   (resp_keep),
        .rdata_o (tag_head),
        .count_o (tag_cnt)
    );

    sync_fifo #(
        .WIDTH     (2*XLEN),
        .DEPTH     (DEPTH),
        .RESET_VAL ({RESET_PC, {XLEN{1'b0}}})
    ) u_instr_q (
        .clk     (clk),
        .rst     (reset),
        .flush_i (redirect),
        .push_i  (resp_keep),
        .wdata_i ({tag_head, imem_resp_data}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt)
    );

endmodule
